// File: rtl/pod_sim_pkg.sv
// Shared types and encodings for the pod simulation sequencer.
// Covers the FSM states, command opcodes, stop reasons and the 64-bit signed datapath type.
package pod_sim_pkg;

    typedef logic signed [63:0] s64_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_SINGLE   = 3'd2,
        ST_HALTED   = 3'd3,
        ST_FINISHED = 3'd4
    } pod_state_e;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_START = 2'd1,
        OP_HALT  = 2'd2,
        OP_STEP  = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        STOP_NONE      = 2'd0,
        STOP_TRACK_END = 2'd1,
        STOP_BRAKE     = 2'd2
    } stop_reason_e;

endpackage

// File: rtl/pod_integrator.sv
// Position/velocity integrator: one step per enabled edge, wrapping 64-bit arithmetic.
// Position advances by the velocity held before the step.
module pod_integrator
    import pod_sim_pkg::*;
(
    input  logic               clk_200khz,
    input  logic               rst,
    input  logic               step_en,
    input  logic               load_en,
    input  logic signed [63:0] accel,
    input  logic signed [63:0] init_pos,
    input  logic signed [63:0] init_vel,
    output logic signed [63:0] position,
    output logic signed [63:0] velocity
);

    always_ff @(posedge clk_200khz) begin
        if (rst) begin
            position <= '0;
            velocity <= '0;
        end else if (load_en) begin
            position <= init_pos;
            velocity <= init_vel;
        end else if (step_en) begin
            position <= position + velocity;
            velocity <= velocity + accel;
        end
    end

endmodule

// File: rtl/pod_sim_sequencer.sv
// Pod simulation sequencer: command FSM, brake/thrust arbiter and stop detection around pod_integrator.
// state    | meaning
// IDLE     | loaded, waiting for START or STEP
// RUN      | integrating every edge until HALT or a stop event
// SINGLE   | one integration step, then HALTED
// HALTED   | paused; LOAD, START or STEP accepted
// FINISHED | track end reached; only LOAD leaves
module pod_sim_sequencer
    import pod_sim_pkg::*;
#(
    parameter logic signed [63:0] TRACK_LEN = 64'sd1_250_000_000,
    parameter int                 STEP_W    = 32
) (
    input  logic               clk_200khz,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic signed [63:0] init_pos,
    input  logic signed [63:0] init_vel,
    input  logic               thr_req,
    input  logic signed [63:0] thr_accel,
    input  logic               brk_req,
    input  logic signed [63:0] brk_accel,
    output logic signed [63:0] position,
    output logic signed [63:0] velocity,
    output logic signed [63:0] accel_applied,
    output logic [1:0]         grant,
    output logic [2:0]         state,
    output logic [STEP_W-1:0]  step_count,
    output logic [1:0]         stop_reason
);

    localparam logic [2:0] S_IDLE     = 3'(ST_IDLE);
    localparam logic [2:0] S_RUN      = 3'(ST_RUN);
    localparam logic [2:0] S_SINGLE   = 3'(ST_SINGLE);
    localparam logic [2:0] S_HALTED   = 3'(ST_HALTED);
    localparam logic [2:0] S_FINISHED = 3'(ST_FINISHED);

    logic               cmd_fire, load_en, step_en;
    logic               brake_stop, track_end;
    logic [1:0]         grant_n;
    logic signed [63:0] accel_n, int_accel, vel_sum, pos_next;

    assign cmd_ready = (state != S_SINGLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign load_en   = cmd_fire && (cmd_op == OP_LOAD) &&
                       (state == S_IDLE || state == S_HALTED || state == S_FINISHED);
    assign step_en   = (state == S_SINGLE) ||
                       (state == S_RUN && !(cmd_fire && cmd_op == OP_HALT));

    always_comb begin
        grant_n = 2'b00;
        accel_n = '0;
        if (brk_req) begin
            grant_n = 2'b10;
            accel_n = brk_accel;
        end else if (thr_req) begin
            grant_n = 2'b01;
            accel_n = thr_accel;
        end
    end

    assign vel_sum    = velocity + accel_n;
    assign pos_next   = position + velocity;
    assign brake_stop = brk_req && (velocity > 64'sd0) && (vel_sum <= 64'sd0);
    assign track_end  = (pos_next >= TRACK_LEN);
    // Clamp by feeding -velocity so the integrator lands exactly on zero.
    assign int_accel  = brake_stop ? (64'sd0 - velocity) : accel_n;

    pod_integrator u_integrator (
        .clk_200khz (clk_200khz),
        .rst        (rst),
        .step_en    (step_en),
        .load_en    (load_en),
        .accel      (int_accel),
        .init_pos   (init_pos),
        .init_vel   (init_vel),
        .position   (position),
        .velocity   (velocity)
    );

    always_ff @(posedge clk_200khz) begin
        if (rst) begin
            state         <= S_IDLE;
            step_count    <= '0;
            stop_reason   <= STOP_NONE;
            grant         <= 2'b00;
            accel_applied <= '0;
        end else if (load_en) begin
            state       <= S_IDLE;
            step_count  <= '0;
            stop_reason <= STOP_NONE;
        end else if (step_en) begin
            grant         <= grant_n;
            accel_applied <= accel_n;
            if (step_count != '1) begin
                step_count <= step_count + {{(STEP_W-1){1'b0}}, 1'b1};
            end
            if (track_end) begin
                state       <= S_FINISHED;
                stop_reason <= STOP_TRACK_END;
            end else if (brake_stop) begin
                state       <= S_HALTED;
                stop_reason <= STOP_BRAKE;
            end else if (state == S_SINGLE) begin
                state <= S_HALTED;
            end
        end else if (cmd_fire) begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (cmd_op == OP_START) state <= S_RUN;
                    else if (cmd_op == OP_STEP) state <= S_SINGLE;
                end
                S_RUN: begin
                    if (cmd_op == OP_HALT) state <= S_HALTED;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pod_sim_sequencer.sv
// Scoreboard bench for pod_sim_sequencer: directed stimulus queues expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pod_sim_sequencer;

    localparam int K_POS = 0, K_VEL = 1, K_STATE = 2, K_SC = 3, K_GRANT = 4, K_STOP = 5,
                   K_RDY = 6, K_ACC = 7;

    typedef struct {
        string       name;
        int          cyc;
        int          kind;
        logic [63:0] exp;
    } exp_t;

    logic               clk_200khz = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'd0;
    logic signed [63:0] init_pos = '0, init_vel = '0;
    logic               thr_req = 1'b0, brk_req = 1'b0;
    logic signed [63:0] thr_accel = '0, brk_accel = '0;
    logic signed [63:0] position, velocity, accel_applied;
    logic [1:0]         grant;
    logic [2:0]         state;
    logic [2:0]         step_count;
    logic [1:0]         stop_reason;

    exp_t sb[$];
    int   cyc_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    pod_sim_sequencer #(.TRACK_LEN(64'sd100), .STEP_W(3)) dut (
        .clk_200khz    (clk_200khz),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .init_pos      (init_pos),
        .init_vel      (init_vel),
        .thr_req       (thr_req),
        .thr_accel     (thr_accel),
        .brk_req       (brk_req),
        .brk_accel     (brk_accel),
        .position      (position),
        .velocity      (velocity),
        .accel_applied (accel_applied),
        .grant         (grant),
        .state         (state),
        .step_count    (step_count),
        .stop_reason   (stop_reason)
    );

    always #5 clk_200khz = ~clk_200khz;
    always @(posedge clk_200khz) cyc_cnt++;

    function automatic logic [63:0] actual(int k);
        case (k)
            K_POS:   return position;
            K_VEL:   return velocity;
            K_STATE: return {61'b0, state};
            K_SC:    return {61'b0, step_count};
            K_GRANT: return {62'b0, grant};
            K_STOP:  return {62'b0, stop_reason};
            K_RDY:   return {63'b0, cmd_ready};
            default: return accel_applied;
        endcase
    endfunction

    // Monitor: every settled cycle, compare all expectations queued for it.
    always @(negedge clk_200khz) begin
        exp_t        e;
        logic [63:0] a;
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            a = actual(e.kind);
            checks++;
            if (a !== e.exp) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, $signed(a),
                         $signed(e.exp), cyc_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk_200khz);
        #1;
    endtask

    task automatic exp_push(string n, int k, logic [63:0] v);
        exp_t t;
        t.name = n;
        t.cyc  = cyc_cnt;
        t.kind = k;
        t.exp  = v;
        sb.push_back(t);
    endtask

    task automatic exp_core(string tag, logic [2:0] st, longint pos, longint vel, int sc);
        exp_push({tag, "_state"}, K_STATE, {61'b0, st});
        exp_push({tag, "_pos"}, K_POS, pos);
        exp_push({tag, "_vel"}, K_VEL, vel);
        exp_push({tag, "_step_count"}, K_SC, 64'(sc));
    endtask

    task automatic cmd(logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic load(longint p, longint v);
        init_pos = p;
        init_vel = v;
        cmd(2'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        exp_core("rst", 3'd0, 0, 0, 0);
        exp_push("rst_grant", K_GRANT, 0);
        exp_push("rst_stop", K_STOP, 0);
        exp_push("rst_ready", K_RDY, 1);
        exp_push("rst_accel", K_ACC, 0);
        rst = 1'b0;

        // Thrust run: 4 steps of +2 then HALT
        load(0, 0);
        exp_core("load_a", 3'd0, 0, 0, 0);
        thr_req = 1'b1; thr_accel = 2;
        cmd(2'd1);
        exp_core("start_a", 3'd1, 0, 0, 0);
        repeat (4) tick();
        cmd(2'd2);
        exp_core("halt_a", 3'd3, 12, 8, 4);
        exp_push("halt_a_grant", K_GRANT, 64'd1);
        exp_push("halt_a_accel", K_ACC, 64'd2);

        // Single step from HALTED, brake beats thrust
        thr_req = 1'b0;
        load(0, 10);
        cmd(2'd1);
        cmd(2'd2);
        exp_core("pre_single", 3'd3, 0, 10, 0);
        brk_req = 1'b1; brk_accel = -3;
        thr_req = 1'b1; thr_accel = 2;
        cmd(2'd3);
        exp_push("single_ready", K_RDY, 0);
        exp_push("single_state", K_STATE, 64'd2);
        tick();
        exp_core("single_done", 3'd3, 10, 7, 1);
        exp_push("single_grant", K_GRANT, 64'd2);
        exp_push("single_ready_back", K_RDY, 1);
        tick();
        exp_core("single_hold", 3'd3, 10, 7, 1);

        // Brake stop clamps velocity
        thr_req = 1'b0;
        load(0, 5);
        brk_req = 1'b1; brk_accel = -7;
        cmd(2'd1);
        tick();
        exp_core("brake", 3'd3, 5, 0, 1);
        exp_push("brake_stop", K_STOP, 64'd2);
        exp_push("brake_accel", K_ACC, -64'sd7);
        exp_push("brake_grant", K_GRANT, 64'd2);
        tick();
        exp_push("brake_sticky", K_STOP, 64'd2);

        // Track end, ignored commands, LOAD out of FINISHED
        brk_req = 1'b0;
        load(95, 10);
        exp_push("load_clears_stop", K_STOP, 0);
        cmd(2'd1);
        tick();
        exp_core("track", 3'd4, 105, 10, 1);
        exp_push("track_stop", K_STOP, 64'd1);
        cmd(2'd1);
        exp_core("fin_start_ign", 3'd4, 105, 10, 1);
        cmd(2'd3);
        exp_core("fin_step_ign", 3'd4, 105, 10, 1);
        exp_push("fin_ready", K_RDY, 1);
        load(0, 0);
        exp_core("fin_load", 3'd0, 0, 0, 0);
        exp_push("fin_load_stop", K_STOP, 0);

        // Reset mid-RUN with a simultaneous START
        load(0, 3);
        thr_req = 1'b1; thr_accel = 1;
        cmd(2'd1);
        tick();
        tick();
        exp_core("run_pre_rst", 3'd1, 7, 5, 2);
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1;
        tick();
        exp_core("mid_rst", 3'd0, 0, 0, 0);
        exp_push("mid_rst_grant", K_GRANT, 0);
        exp_push("mid_rst_accel", K_ACC, 0);
        exp_push("mid_rst_stop", K_STOP, 0);
        rst = 1'b0; cmd_valid = 1'b0; thr_req = 1'b0;
        tick();
        exp_core("post_rst", 3'd0, 0, 0, 0);

        // Track end and brake stop on the same edge
        load(96, 4);
        brk_req = 1'b1; brk_accel = -4;
        cmd(2'd1);
        tick();
        exp_core("conflict", 3'd4, 100, 0, 1);
        exp_push("conflict_stop", K_STOP, 64'd1);
        brk_req = 1'b0;

        // Step counter saturation (3-bit)
        load(0, 0);
        cmd(2'd1);
        repeat (9) tick();
        exp_core("sat", 3'd1, 0, 0, 7);
        cmd(2'd2);
        exp_core("sat_halt", 3'd3, 0, 0, 7);

        tick();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_200khz);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
